nvram_save_scheduler: RTL and testbench

Sequences the NVRAM backup engine.
- Raises its load_req after an image mount and its save_req on user request or on autosave.
- Autosave fires once the SRAM regions have been written and the CPU has then stopped writing for a set time, or after a maximum dirty age.
- Sits between the OSD/HPS glue and nvram_backup, and serialises requests against the engine's busy flag.

---
 rtl/nvram_save_scheduler_pkg.sv | 13 +
 rtl/nvram_save_scheduler_ms_ticker.sv | 29 ++
 rtl/nvram_save_scheduler.sv | 132 +++++++++++++
 tb/tb_nvram_save_scheduler.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvram_save_scheduler_pkg.sv
// Shared types and helpers for the NVRAM save/load request scheduler.
package nvram_save_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} sched_state_t;
  typedef enum logic {LOAD, SAVE} req_kind_t;

  localparam int MS_W = 16;

  function automatic logic [MS_W-1:0] sat_inc(input logic [MS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nvram_save_scheduler_ms_ticker.sv
// Free-running 1 ms prescaler; o_tick is high for one cycle each time the count wraps.
module nvram_save_scheduler_ms_ticker #(
  parameter int CLK_HZ = 21477270
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_tick
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nvram_save_scheduler.sv
// Issues load/save pulses to nvram_backup on mounts, OSD requests and autosave timeouts,
// one at a time, waiting out the engine's busy flag between requests.
module nvram_save_scheduler
  import nvram_save_scheduler_pkg::*;
#(
  parameter int CLK_HZ  = 21477270,
  parameter int IDLE_MS = 2000,
  parameter int MAX_MS  = 10000
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [3:0]   i_img_mounted,
  input  logic         i_img_readonly,
  input  logic [3:0]   i_sram_wr,
  input  logic         i_osd_save,
  input  logic         i_autosave_en,
  input  logic         i_backup_busy,
  output logic         o_load_req,
  output logic         o_save_req,
  output logic [3:0]   o_dirty,
  output logic         o_busy,
  output sched_state_t o_state
);

  // Handshake: o_load_req/o_save_req are single-cycle pulses; the engine raises
  // i_backup_busy a couple of cycles later and holds it until the job is done.

  sched_state_t    r_state;
  req_kind_t       r_kind;
  logic            r_guard;
  logic            r_load_req, r_save_req, r_busy;
  logic [3:0]      r_dirty;
  logic [MS_W-1:0] r_idle_ms, r_age_ms;
  logic            r_load_pend, r_save_pend, r_osd_q;

  logic w_tick, w_mount, w_osd_rise, w_issue_load, w_issue_save, w_autosave;

  nvram_save_scheduler_ms_ticker #(.CLK_HZ(CLK_HZ)) u_ticker (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_tick    (w_tick)
  );

  assign w_mount      = (|i_img_mounted) & ~i_img_readonly;
  assign w_osd_rise   = i_osd_save & ~r_osd_q;
  assign w_issue_load = (r_state == ISSUE) && (r_kind == LOAD);
  assign w_issue_save = (r_state == ISSUE) && (r_kind == SAVE);
  assign w_autosave   = i_autosave_en && (r_dirty != 4'b0) &&
                        ((r_idle_ms >= MS_W'(IDLE_MS)) || (r_age_ms >= MS_W'(MAX_MS)));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_osd_q     <= 1'b0;
      r_dirty     <= 4'b0;
      r_idle_ms   <= '0;
      r_age_ms    <= '0;
      r_load_pend <= 1'b0;
      r_save_pend <= 1'b0;
    end else begin
      r_osd_q <= i_osd_save;
      // A write landing in the save-issue cycle re-marks its channel.
      r_dirty <= (w_issue_save ? 4'b0 : r_dirty) | i_sram_wr;
      if ((|i_sram_wr) || (r_dirty == 4'b0)) begin
        r_idle_ms <= '0;
      end else if (w_tick) begin
        r_idle_ms <= sat_inc(r_idle_ms);
      end
      if (r_dirty == 4'b0) begin
        r_age_ms <= '0;
      end else if (w_tick) begin
        r_age_ms <= sat_inc(r_age_ms);
      end
      r_load_pend <= (r_load_pend & ~w_issue_load) | w_mount;
      r_save_pend <= (r_save_pend & ~w_issue_save) | w_osd_rise;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_kind     <= LOAD;
      r_guard    <= 1'b0;
      r_load_req <= 1'b0;
      r_save_req <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_load_req <= 1'b0;
      r_save_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_load_pend) begin
            r_state <= ISSUE;
            r_kind  <= LOAD;
            r_busy  <= 1'b1;
          end else if (r_save_pend || w_autosave) begin
            r_state <= ISSUE;
            r_kind  <= SAVE;
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          r_load_req <= (r_kind == LOAD);
          r_save_req <= (r_kind == SAVE);
          r_guard    <= 1'b0;
          r_state    <= GUARD;
        end
        // Busy is not yet valid here: the engine needs two cycles to see the pulse.
        GUARD: begin
          if (r_guard) r_state <= WAIT;
          else         r_guard <= 1'b1;
        end
        WAIT: begin
          if (!i_backup_busy) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_load_req = r_load_req;
  assign o_save_req = r_save_req;
  assign o_dirty    = r_dirty;
  assign o_busy     = r_busy;
  assign o_state    = r_state;

endmodule

// File: tb/tb_nvram_save_scheduler.sv
// Bench for nvram_save_scheduler: scenario tasks plus random traffic, checked against a
// time-based reference model of the scheduling rules.
module tb_nvram_save_scheduler;
  import nvram_save_scheduler_pkg::*;

  localparam int CLK_HZ = 4000;
  localparam int IDLE_MS = 3;
  localparam int MAX_MS = 10;
  localparam int CYC_PER_MS = CLK_HZ / 1000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   img_mounted;
  logic         img_readonly;
  logic [3:0]   sram_wr;
  logic         osd_save, autosave_en, backup_busy;
  logic         load_req, save_req, busy;
  logic [3:0]   dirty;
  sched_state_t state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nvram_save_scheduler #(.CLK_HZ(CLK_HZ), .IDLE_MS(IDLE_MS), .MAX_MS(MAX_MS)) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_img_mounted  (img_mounted),
    .i_img_readonly (img_readonly),
    .i_sram_wr      (sram_wr),
    .i_osd_save     (osd_save),
    .i_autosave_en  (autosave_en),
    .i_backup_busy  (backup_busy),
    .o_load_req     (load_req),
    .o_save_req     (save_req),
    .o_dirty        (dirty),
    .o_busy         (busy),
    .o_state        (state)
  );

  // Reference model: the scheduler is "free" or holds one request whose pulse edge is known;
  // it is free again at the first edge >= pulse+3 that sees backup_busy low.
  int       m_cyc;
  bit [3:0] m_dirty;
  int       m_idle, m_age;
  bit       m_lpend, m_spend, m_osd_q, m_free, m_kind_save;
  int       m_pulse_at;
  bit       e_load, e_save, e_busy;

  int edge_no = 0;
  int last_pulse_edge = -1000;
  int min_gap = 1000;
  int n_load = 0;
  int n_save = 0;

  task automatic model_edge();
    bit [3:0] d0;
    int       i0, a0;
    bit       lp0, sp0, free0, tick, auto_ok;
    if (!reset_n) begin
      m_cyc = 0; m_dirty = 4'b0; m_idle = 0; m_age = 0;
      m_lpend = 0; m_spend = 0; m_osd_q = 0; m_free = 1; m_kind_save = 0; m_pulse_at = 0;
      e_load = 0; e_save = 0; e_busy = 0;
      return;
    end
    m_cyc++;
    tick = (m_cyc % CYC_PER_MS) == 0;
    d0 = m_dirty; i0 = m_idle; a0 = m_age; lp0 = m_lpend; sp0 = m_spend; free0 = m_free;
    e_load = !free0 && (m_cyc == m_pulse_at) && !m_kind_save;
    e_save = !free0 && (m_cyc == m_pulse_at) && m_kind_save;
    auto_ok = autosave_en && (d0 != 0) && (i0 >= IDLE_MS || a0 >= MAX_MS);
    if (free0) begin
      if (lp0) begin
        m_free = 0; m_pulse_at = m_cyc + 1; m_kind_save = 0;
      end else if (sp0 || auto_ok) begin
        m_free = 0; m_pulse_at = m_cyc + 1; m_kind_save = 1;
      end
    end else if (m_cyc >= m_pulse_at + 3 && !backup_busy) begin
      m_free = 1;
    end
    e_busy = !m_free;
    m_dirty = (e_save ? 4'b0 : d0) | sram_wr;
    if (sram_wr != 0 || d0 == 0) m_idle = 0;
    else if (tick && i0 < 65535) m_idle = i0 + 1;
    if (d0 == 0) m_age = 0;
    else if (tick && a0 < 65535) m_age = a0 + 1;
    m_lpend = (lp0 && !e_load) || ((img_mounted != 0) && !img_readonly);
    m_spend = (sp0 && !e_save) || (osd_save && !m_osd_q);
    m_osd_q = osd_save;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    edge_no++;
    @(negedge clk);
    if (load_req === 1'b1) n_load++;
    if (save_req === 1'b1) n_save++;
    if (load_req === 1'b1 || save_req === 1'b1) begin
      if (edge_no - last_pulse_edge < min_gap) min_gap = edge_no - last_pulse_edge;
      last_pulse_edge = edge_no;
    end
    img_mounted = 4'b0;
    sram_wr = 4'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({load_req, save_req, busy, dirty} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got l=%b s=%b b=%b d=%b want all 0", load_req, save_req, busy, dirty);
    end
    checks++;
    if (state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d want IDLE", state);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_mount();
    int n0;
    img_readonly = 1'b0;
    img_mounted = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({load_req, save_req, busy, dirty} !== {e_load, e_save, e_busy, m_dirty}) begin
        errors++;
        $display("FAIL mount_model t=%0t got l=%b s=%b b=%b d=%b want l=%b s=%b b=%b d=%b",
                 $time, load_req, save_req, busy, dirty, e_load, e_save, e_busy, m_dirty);
      end
      checks++;
      if (load_req !== (k == 2)) begin
        errors++;
        $display("FAIL mount_latency cycle %0d got load_req=%b want %b", k, load_req, k == 2);
      end
    end
    backup_busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (busy !== 1'b1 || load_req !== 1'b0) begin
        errors++;
        $display("FAIL mount_hold cycle %0d got busy=%b load_req=%b want busy=1 load_req=0", k, busy, load_req);
      end
    end
    backup_busy = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || busy !== e_busy) begin
      errors++;
      $display("FAIL mount_release got busy=%b want 0", busy);
    end
    n0 = n_load;
    img_readonly = 1'b1;
    img_mounted = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      step();
      img_readonly = 1'b0;
      checks++;
      if ({load_req, save_req, busy, dirty} !== {e_load, e_save, e_busy, m_dirty}) begin
        errors++;
        $display("FAIL readonly_model t=%0t got l=%b s=%b b=%b d=%b want l=%b s=%b b=%b d=%b",
                 $time, load_req, save_req, busy, dirty, e_load, e_save, e_busy, m_dirty);
      end
    end
    checks++;
    if (n_load !== n0) begin
      errors++;
      $display("FAIL readonly_no_load got %0d pulses want 0", n_load - n0);
    end
  endtask

  task automatic test_idle_autosave();
    int lat;
    int n0;
    lat = -1;
    n0 = n_save;
    autosave_en = 1'b1;
    sram_wr = 4'b0001;
    step();
    checks++;
    if (dirty !== 4'b0001) begin
      errors++;
      $display("FAIL idle_dirty_set got %b want 0001", dirty);
    end
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      step();
      checks++;
      if ({load_req, save_req, busy, dirty} !== {e_load, e_save, e_busy, m_dirty}) begin
        errors++;
        $display("FAIL idle_model t=%0t got l=%b s=%b b=%b d=%b want l=%b s=%b b=%b d=%b",
                 $time, load_req, save_req, busy, dirty, e_load, e_save, e_busy, m_dirty);
      end
      if (save_req === 1'b1) begin
        lat = k;
        checks++;
        if (dirty !== 4'b0) begin
          errors++;
          $display("FAIL idle_dirty_clear got %b want 0000", dirty);
        end
      end
    end
    checks++;
    if (lat < 11 || lat > 14) begin
      errors++;
      $display("FAIL idle_latency got %0d cycles want 11..14 (-1 means timeout)", lat);
    end
    repeat (6) step();
    checks++;
    if (n_save - n0 !== 1) begin
      errors++;
      $display("FAIL idle_save_count got %0d want 1", n_save - n0);
    end
  endtask

  task automatic test_forced_save();
    int lat;
    int n0;
    lat = -1;
    n0 = n_save;
    autosave_en = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      if (k % 8 == 0) sram_wr = 4'b1000;
      step();
      checks++;
      if ({load_req, save_req, busy, dirty} !== {e_load, e_save, e_busy, m_dirty}) begin
        errors++;
        $display("FAIL forced_model t=%0t got l=%b s=%b b=%b d=%b want l=%b s=%b b=%b d=%b",
                 $time, load_req, save_req, busy, dirty, e_load, e_save, e_busy, m_dirty);
      end
      if (save_req === 1'b1 && lat < 0) lat = k;
    end
    autosave_en = 1'b0;
    checks++;
    if (lat < 39 || lat > 42) begin
      errors++;
      $display("FAIL forced_latency got %0d cycles want 39..42 (-1 means timeout)", lat);
    end
    checks++;
    if (n_save - n0 !== 1) begin
      errors++;
      $display("FAIL forced_save_count got %0d want 1", n_save - n0);
    end
    checks++;
    if (dirty[3] !== 1'b1) begin
      errors++;
      $display("FAIL forced_remark got dirty=%b want bit3 set", dirty);
    end
  endtask

  task automatic test_collisions();
    int kinds[$];
    int hold;
    int since_save;
    bit osd_done;
    hold = 0; since_save = 0; osd_done = 0;
    min_gap = 1000;
    autosave_en = 1'b0;
    img_readonly = 1'b0;
    img_mounted = 4'b0001;
    osd_save = 1'b1;
    for (int k = 0; k < 200 && kinds.size() < 3; k++) begin
      step();
      checks++;
      if ({load_req, save_req, busy, dirty} !== {e_load, e_save, e_busy, m_dirty}) begin
        errors++;
        $display("FAIL collide_model t=%0t got l=%b s=%b b=%b d=%b want l=%b s=%b b=%b d=%b",
                 $time, load_req, save_req, busy, dirty, e_load, e_save, e_busy, m_dirty);
      end
      if (k == 0) osd_save = 1'b0;
      if (load_req === 1'b1) kinds.push_back(0);
      if (save_req === 1'b1) begin
        kinds.push_back(1);
        since_save = 0;
      end else begin
        since_save++;
      end
      if (load_req === 1'b1 || save_req === 1'b1) hold = $urandom_range(6, 12);
      backup_busy = (hold > 0);
      if (hold > 0) hold--;
      if (kinds.size() == 2 && since_save == 3 && !osd_done) begin
        osd_save = 1'b1;
        osd_done = 1'b1;
      end
    end
    backup_busy = 1'b0;
    repeat (8) step();
    checks++;
    if (kinds.size() != 3) begin
      errors++;
      $display("FAIL collide_count got %0d pulses want 3", kinds.size());
    end else begin
      checks++;
      if (kinds[0] != 0 || kinds[1] != 1 || kinds[2] != 1) begin
        errors++;
        $display("FAIL collide_order got %0d,%0d,%0d want 0,1,1 (0=load 1=save)", kinds[0], kinds[1], kinds[2]);
      end
    end
    checks++;
    if (min_gap < 4) begin
      errors++;
      $display("FAIL collide_spacing got %0d cycles want >= 4", min_gap);
    end
  endtask

  task automatic test_write_on_save();
    bit found;
    int n0;
    found = 0;
    autosave_en = 1'b0;
    osd_save = 1'b0;
    step();
    osd_save = 1'b1;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (save_req === 1'b1) begin
        found = 1;
        sram_wr = 4'b0010;
        step();
        checks++;
        if (dirty !== 4'b0010 || dirty !== m_dirty) begin
          errors++;
          $display("FAIL write_on_save got dirty=%b want 0010", dirty);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL write_on_save_timeout got no save_req want one within 10 cycles");
    end
    repeat (5) step();
    n0 = n_save;
    for (int k = 0; k < 60; k++) begin
      step();
      checks++;
      if ({load_req, save_req, busy, dirty} !== {e_load, e_save, e_busy, m_dirty}) begin
        errors++;
        $display("FAIL noauto_model t=%0t got l=%b s=%b b=%b d=%b want l=%b s=%b b=%b d=%b",
                 $time, load_req, save_req, busy, dirty, e_load, e_save, e_busy, m_dirty);
      end
    end
    checks++;
    if (n_save !== n0 || dirty !== 4'b0010) begin
      errors++;
      $display("FAIL noauto got %0d saves dirty=%b want 0 saves dirty=0010", n_save - n0, dirty);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    autosave_en = 1'b0;
    osd_save = 1'b0;
    img_readonly = 1'b0;
    img_mounted = 4'b1000;
    repeat (3) step();
    backup_busy = 1'b1;
    repeat (4) step();
    sram_wr = 4'b1111;
    osd_save = 1'b1;
    step();
    checks++;
    if (state !== WAIT || dirty !== 4'b1111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup got state=%0d dirty=%b busy=%b want WAIT 1111 1", state, dirty, busy);
    end
    reset_n = 1'b0;
    osd_save = 1'b0;
    step();
    checks++;
    if ({load_req, save_req, busy, dirty} !== 7'b0 || state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid got l=%b s=%b b=%b d=%b state=%0d want all 0 IDLE",
               load_req, save_req, busy, dirty, state);
    end
    reset_n = 1'b1;
    backup_busy = 1'b0;
    n0 = n_load + n_save;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if ({load_req, save_req, busy, dirty} !== {e_load, e_save, e_busy, m_dirty}) begin
        errors++;
        $display("FAIL reset_mid_model t=%0t got l=%b s=%b b=%b d=%b want l=%b s=%b b=%b d=%b",
                 $time, load_req, save_req, busy, dirty, e_load, e_save, e_busy, m_dirty);
      end
    end
    checks++;
    if (n_load + n_save !== n0) begin
      errors++;
      $display("FAIL reset_mid_no_pulse got %0d pulses want 0", n_load + n_save - n0);
    end
  endtask

  task automatic test_random();
    min_gap = 1000;
    for (int k = 0; k < 600; k++) begin
      img_mounted = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      img_readonly = ($urandom_range(0, 3) == 0);
      sram_wr = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      if ($urandom_range(0, 14) == 0) osd_save = ~osd_save;
      if (k % 150 == 0) autosave_en = ($urandom_range(0, 3) != 0);
      if (backup_busy) backup_busy = ($urandom_range(0, 4) != 0);
      else backup_busy = ($urandom_range(0, 6) == 0);
      step();
      checks++;
      if ({load_req, save_req, busy, dirty} !== {e_load, e_save, e_busy, m_dirty}) begin
        errors++;
        $display("FAIL random_model t=%0t got l=%b s=%b b=%b d=%b want l=%b s=%b b=%b d=%b",
                 $time, load_req, save_req, busy, dirty, e_load, e_save, e_busy, m_dirty);
      end
    end
    checks++;
    if (min_gap < 4) begin
      errors++;
      $display("FAIL random_spacing got %0d cycles want >= 4", min_gap);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    img_mounted = 4'b0;
    img_readonly = 1'b0;
    sram_wr = 4'b0;
    osd_save = 1'b0;
    autosave_en = 1'b0;
    backup_busy = 1'b0;
    test_reset();
    test_mount();
    test_idle_autosave();
    test_forced_save();
    test_collisions();
    test_write_on_save();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
